// File: rtl/receiver.sv
// receiver: 16x-oversampling 8N1 serial deserializer with a one-cycle byte strobe.
// Define RECEIVER_FERR_EN to check the stop bit (rx_ferr pulse + BREAK recovery).
module receiver #(
    parameter int CLKS_PER_TICK = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] rx_data,
    output logic       rx_status,
    output logic       rx_ferr
);
    localparam int DW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_TICK - 1);

`ifdef RECEIVER_FERR_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t          r_state;
    logic [1:0]      r_sync;
    logic [DW-1:0]   r_div;
    logic [3:0]      r_tcnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic [7:0]      r_data;
    logic            r_status;
    logic            w_sdin;
    logic            w_tick;

    assign w_sdin    = r_sync[1];
    assign w_tick    = (r_div == DIV_LAST);
    assign rx_data   = r_data;
    assign rx_status = r_status;

`ifdef RECEIVER_FERR_EN
    logic r_ferr;
    assign rx_ferr = r_ferr;
`else
    assign rx_ferr = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync   <= 2'b11;
            r_div    <= '0;
            r_tcnt   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_data   <= '0;
            r_status <= 1'b0;
            r_state  <= S_IDLE;
`ifdef RECEIVER_FERR_EN
            r_ferr   <= 1'b0;
`endif
        end else begin
            r_sync   <= {r_sync[0], din};
            r_status <= 1'b0;
`ifdef RECEIVER_FERR_EN
            r_ferr   <= 1'b0;
`endif
            r_div    <= w_tick ? '0 : r_div + 1'b1;
            case (r_state)
                S_IDLE: begin
                    // Re-phase the divider so ticks line up with the start edge
                    if (!w_sdin) begin
                        r_state <= S_START;
                        r_div   <= '0;
                        r_tcnt  <= '0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_tcnt <= r_tcnt + 4'd1;
                        if (r_tcnt == 4'd7) begin
                            r_tcnt  <= '0;
                            r_bit   <= '0;
                            r_state <= w_sdin ? S_IDLE : S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_tcnt <= r_tcnt + 4'd1;
                        if (r_tcnt == 4'd15) begin
                            r_shift[r_bit] <= w_sdin;
                            r_bit          <= r_bit + 3'd1;
                            if (r_bit == 3'd7)
                                r_state <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_tcnt <= r_tcnt + 4'd1;
                        if (r_tcnt == 4'd15) begin
`ifdef RECEIVER_FERR_EN
                            if (w_sdin) begin
                                r_data   <= r_shift;
                                r_status <= 1'b1;
                                r_state  <= S_IDLE;
                            end else begin
                                r_ferr  <= 1'b1;
                                r_state <= S_BREAK;
                            end
`else
                            r_data   <= r_shift;
                            r_status <= 1'b1;
                            r_state  <= S_IDLE;
`endif
                        end
                    end
                end
`ifdef RECEIVER_FERR_EN
                S_BREAK: begin
                    if (w_sdin)
                        r_state <= S_IDLE;
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_receiver.sv
// Bench for receiver: line-level reference model checked every cycle, plus
// hand-computed checks on strobe timing and received bytes.
module tb_receiver;
    localparam int CPT = 4;
    localparam int BIT = 16 * CPT;
`ifdef RECEIVER_FERR_EN
    localparam bit FERR = 1'b1;
`else
    localparam bit FERR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b1;
    logic [7:0] rx_data;
    logic       rx_status;
    logic       rx_ferr;

    receiver #(.CLKS_PER_TICK(CPT)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .rx_data  (rx_data),
        .rx_status(rx_status),
        .rx_ferr  (rx_ferr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ferr_cnt = 0;
    int stq[$];
    logic [7:0] sdq[$];

    // Reference model: frame start D is the first cycle the synchronized line is
    // low while idle; samples land at D + (8 + 16k) * CPT.
    bit         ms0 = 1'b1, ms1 = 1'b1;
    int         mst = 0;             // 0 idle, 1 in frame, 2 break
    int         mD  = 0;
    logic [7:0] mbits = 8'h00;
    logic       nxt_st = 1'b0, nxt_fe = 1'b0;
    logic [7:0] nxt_d = 8'h00;
    logic       ex_st = 1'b0, ex_fe = 1'b0;
    logic [7:0] ex_d = 8'h00;

    function automatic void step(bit sd);
        int off, k;
        case (mst)
            0: if (!sd) begin mst = 1; mD = cyc; end
            1: begin
                off = cyc - mD;
                if (off == 8 * CPT) begin
                    if (sd) mst = 0;
                end else if (off > 8 * CPT && (off - 8 * CPT) % BIT == 0) begin
                    k = (off - 8 * CPT) / BIT;
                    if (k <= 8) mbits[k-1] = sd;
                    else if (sd || !FERR) begin
                        nxt_st = 1'b1; nxt_d = mbits; mst = 0;
                    end else begin
                        nxt_fe = 1'b1; mst = 2;
                    end
                end
            end
            default: if (sd) mst = 0;
        endcase
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            ms0 = 1'b1; ms1 = 1'b1; mst = 0; mbits = 8'h00;
            nxt_st = 1'b0; nxt_fe = 1'b0;
            ex_st = 1'b0; ex_fe = 1'b0; ex_d = 8'h00;
        end else begin
            ms1 = ms0; ms0 = din;
            ex_st = nxt_st; ex_fe = nxt_fe;
            if (nxt_st) ex_d = nxt_d;
            nxt_st = 1'b0; nxt_fe = 1'b0;
            step(ms1);
        end
    end

    always @(posedge clk) begin
        #2;
        n_tests++;
        if (rx_status !== ex_st || rx_ferr !== ex_fe || rx_data !== ex_d) begin
            n_fail++;
            $display("FAIL model cyc %0d: status/ferr/data got %b/%b/%h want %b/%b/%h",
                     cyc, rx_status, rx_ferr, rx_data, ex_st, ex_fe, ex_d);
        end
        if (rx_status === 1'b1) begin stq.push_back(cyc); sdq.push_back(rx_data); end
        if (rx_ferr === 1'b1) ferr_cnt++;
    end

    task automatic chk(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    // Called at a negedge: drive the line and hold it for n cycles.
    task automatic hold(input bit v, input int n);
        din = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input bit stopv, output int f);
        f = cyc;
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(b[i], BIT);
        hold(stopv, BIT);
    endtask

    initial begin
        int f, f2, fe0;
        @(negedge clk); @(negedge clk);
        chk("reset_data", rx_data, 8'h00);
        chk("reset_status", rx_status, 0);
        chk("reset_ferr", rx_ferr, 0);
        rst = 1'b0;
        hold(1'b1, 20);

        // single frame: strobe at D+609 where D = fall + 2
        stq.delete(); sdq.delete();
        send(8'hA5, 1'b1, f);
        hold(1'b1, BIT);
        chk("a5_count", stq.size(), 1);
        if (stq.size() >= 1) begin
            chk("a5_data", sdq[0], 8'hA5);
            chk("a5_time", stq[0] - f, 611);
        end
        chk("a5_ferr", ferr_cnt, 0);

        // 20-clk glitch is rejected
        stq.delete(); sdq.delete();
        hold(1'b0, 20);
        hold(1'b1, 3 * BIT);
        chk("glitch_count", stq.size(), 0);
        chk("glitch_ferr", ferr_cnt, 0);
        chk("glitch_data", rx_data, 8'hA5);

        // back-to-back frames
        stq.delete(); sdq.delete();
        send(8'h00, 1'b1, f);
        send(8'hFF, 1'b1, f2);
        hold(1'b1, BIT);
        chk("b2b_count", stq.size(), 2);
        if (stq.size() == 2) begin
            chk("b2b_gap", stq[1] - stq[0], 640);
            chk("b2b_first", sdq[0], 8'h00);
            chk("b2b_second", sdq[1], 8'hFF);
        end

        // bad stop bit, long low hold, then a good frame
        stq.delete(); sdq.delete();
        fe0 = ferr_cnt;
        send(8'h3C, 1'b0, f);
        hold(1'b0, 200);
        hold(1'b1, 700);
        send(8'h5A, 1'b1, f2);
        hold(1'b1, BIT);
        if (FERR) begin
            chk("ferr_pulses", ferr_cnt - fe0, 1);
            chk("ferr_strobes", stq.size(), 1);
            if (stq.size() >= 1) chk("ferr_next_data", sdq[0], 8'h5A);
        end else begin
            chk("noferr_pulses", ferr_cnt - fe0, 0);
            // the low hold looks like a frame 0xF8 once the stop is not checked
            chk("noferr_strobes", stq.size(), 3);
            if (stq.size() == 3) begin
                chk("noferr_3c", sdq[0], 8'h3C);
                chk("noferr_hold", sdq[1], 8'hF8);
                chk("noferr_5a", sdq[2], 8'h5A);
            end
        end
        chk("after_5a_data", rx_data, 8'h5A);

        // reset during data bit 4 of 0x81; the sender is reset too
        stq.delete(); sdq.delete();
        hold(1'b0, BIT);
        hold(1'b1, BIT);
        for (int i = 1; i < 4; i++) hold(1'b0, BIT);
        hold(1'b0, 20);
        rst = 1'b1;
        din = 1'b1;
        #1;
        chk("rst_data", rx_data, 8'h00);
        chk("rst_status", rx_status, 0);
        chk("rst_ferr", rx_ferr, 0);
        @(negedge clk);
        hold(1'b1, 3);
        rst = 1'b0;
        hold(1'b1, 8 * BIT);
        chk("rst_no_strobe", stq.size(), 0);
        send(8'h7E, 1'b1, f);
        hold(1'b1, BIT);
        chk("7e_count", stq.size(), 1);
        if (stq.size() >= 1) begin
            chk("7e_data", sdq[0], 8'h7E);
            chk("7e_time", stq[0] - f, 611);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/receiver.md
# receiver

Serial-line receiver that sits directly downstream of `sender`. It deserializes frames of 1 start bit (0), 8 data bits (LSB first) and 1 stop bit (1) from an idle-high line. It oversamples the line 16x using a tick divider derived from the single system clock, and presents each received byte on a parallel bus with a one-cycle strobe.

## Interface
- `CLKS_PER_TICK`, default 27: `clk` cycles per oversample tick. One bit period is 16 ticks (`16*CLKS_PER_TICK` clk). Must be ≥ 2.
- `clk`  input  1  system clock; all state updates on posedge.
- `rst`  input  1  reset; asynchronous, active-high.
- `din`  input  1  serial line, idle high, asynchronous to `clk`.
- `rx_data`  output  8  last correctly framed byte; held until the next one.
- `rx_status`  output  1  one-cycle pulse: `rx_data` updated this cycle.
- `rx_ferr`  output  1  one-cycle pulse: frame error (stop bit sampled 0).

## Operation
- `din` passes through a 2-flop synchronizer; both flops reset to 1. `sdin` is the synchronizer output.
- The tick divider counts 0..`CLKS_PER_TICK`-1 and produces `tick` at the terminal count. The divider is cleared on entry to START.
- Bit-tick counter is 4 bits (0..15), wraps modulo 16. Bit index is 3 bits (0..7).
- State machine:
  - IDLE:
    - `sdin`==0 → START; tick divider and bit-tick counter cleared.
  - START:
    - On the 8th tick (mid start bit), sample `sdin`.
    - Sample 0 → DATA, bit-tick counter cleared.
    - Sample 1 → IDLE. This is a glitch reject; no output activity.
  - DATA:
    - Every 16th tick, sample `sdin` into shift register bit position `bit index` (LSB first).
    - After bit index 7 → STOP.
  - STOP:
    - On the 16th tick, sample `sdin`.
    - Sample 1 → load `rx_data` from the shift register, pulse `rx_status`, go to IDLE.
    - Sample 0 → see Configuration.
  - BREAK: wait until `sdin`==1, then → IDLE. No outputs while in BREAK.
- Shift register contents are never visible on `rx_data` except through a valid stop.
- `rx_status` and `rx_ferr` are never high in the same cycle.

## Timing
- Reset values:
  - `rx_data` = 8'h00, `rx_status` = 0, `rx_ferr` = 0.
  - State = IDLE, counters = 0, shift register = 0.
- Reset asserted mid-frame aborts the frame immediately. No strobe is produced for the aborted frame.
- Let cycle D be the first cycle in which `sdin`==0 in IDLE. D is 2 clk after the `din` falling edge, ±1 for synchronizer metastability.
- Sample instants are at D + (8 + 16k)·`CLKS_PER_TICK`:
  - k=0: start bit.
  - k=1..8: data bits 0..7.
  - k=9: stop bit.
- `rx_status`/`rx_ferr` go high in the cycle after the stop sample, i.e. D + 152·`CLKS_PER_TICK` + 1, for exactly one clk.
- IDLE is re-entered in that same cycle. A start edge arriving half a bit after the stop sample, which is back-to-back framing, is detected with no lost frames.
- Tolerated baud mismatch: ±3% (center sampling).

## Configuration
- `RECEIVER_FERR_EN` defined:
  - Stop sample 0 → pulse `rx_ferr` for one clk, `rx_data` unchanged, no `rx_status`, go to BREAK.
- `RECEIVER_FERR_EN` undefined:
  - The stop bit is not checked. The STOP sample always loads `rx_data` and pulses `rx_status`, then goes to IDLE.
  - BREAK state is absent.
  - `rx_ferr` is tied to 0; the port still exists.

## Test plan
- `CLKS_PER_TICK`=4 (bit = 64 clk), `din` sends frame 0xA5:
  - `rx_data`=8'hA5.
  - `rx_status` high for 1 clk at D+609.
  - `rx_ferr` stays 0.
- `din` pulled low for 20 clk, then high:
  - START samples 1 at D+32 → back to IDLE.
  - No `rx_status` or `rx_ferr`; `rx_data` unchanged.
- Back-to-back frames 0x00 then 0xFF, each with a single stop bit:
  - Two `rx_status` pulses, 640 clk apart.
  - `rx_data` reads 8'h00, then 8'hFF.
- With `RECEIVER_FERR_EN`, frame 0x3C with stop bit 0, line held low for a further 200 clk, then 0x5A:
  - One `rx_ferr` pulse; `rx_data` stays at its prior value.
  - No false start during the low hold.
  - Then `rx_data`=8'h5A with `rx_status`.
- Same stimulus without the macro:
  - `rx_status` with `rx_data`=8'h3C; `rx_ferr` never high.
- `rst` asserted for 3 clk during data bit 4 of frame 0x81:
  - Outputs return to reset values immediately.
  - No strobe for the aborted frame.
  - The next full frame 0x7E is received correctly.
